// File: rtl/calc_operand_if.sv
// Operand-sequencing bus: switch/key front end, adder_8bit drive/return and result/status outputs.
interface calc_operand_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             op_in;
  logic             enter;
  logic             clear;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             negative;
  logic             result_valid;
  logic [1:0]       state_out;

  // Environment side: front end plus the external adder.
  modport master (
    output data_in, op_in, enter, clear, add_sum,
    input  add_a, add_b, add_cin, result, carry_out, negative, result_valid, state_out
  );

  // Sequencer side.
  modport slave (
    input  data_in, op_in, enter, clear, add_sum,
    output add_a, add_b, add_cin, result, carry_out, negative, result_valid, state_out
  );
endinterface

// File: rtl/calc_operand_fsm.sv
// Captures operand A, then operand B and operator, drives adder_8bit and registers its Sum.
// Subtract is performed as A + ~B + 1 through the same adder.
module calc_operand_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  calc_operand_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             op_q,     op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             neg_q,    neg_d;
  logic             valid_q,  valid_d;
  logic             enter_q;
  logic             enter_pulse;

  assign enter_pulse = bus.enter & ~enter_q;

  // Next-state and datapath capture; clear overrides any enter edge.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    neg_d    = neg_q;

    if (bus.clear) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      op_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enter_pulse) begin
            a_d     = bus.data_in;
            state_d = GOT_A;
          end
        end
        GOT_A: begin
          if (enter_pulse) begin
            b_d     = bus.data_in;
            op_d    = bus.op_in;
            state_d = EXEC;
          end
        end
        EXEC: begin
          result_d = bus.add_sum[WIDTH-1:0];
          carry_d  = op_q ? 1'b0 : bus.add_sum[WIDTH];
          neg_d    = op_q ? ~bus.add_sum[WIDTH] : 1'b0;
          state_d  = DONE;
        end
        DONE: begin
          if (enter_pulse) begin
            a_d     = bus.data_in;
            state_d = GOT_A;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      enter_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
      enter_q  <= bus.enter;
    end
  end

  // Adder operands come straight from the captured registers, stable through EXEC.
  assign bus.add_a        = a_q;
  assign bus.add_b        = op_q ? ~b_q : b_q;
  assign bus.add_cin      = op_q;
  assign bus.result       = result_q;
  assign bus.carry_out    = carry_q;
  assign bus.negative     = neg_q;
  assign bus.result_valid = valid_q;
  assign bus.state_out    = state_q;

endmodule

// File: tb/tb_calc_operand_fsm.sv
// Directed and randomized checks of calc_operand_fsm against an arithmetic reference model.
module tb_calc_operand_fsm;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  calc_operand_if #(.WIDTH(WIDTH)) bus ();

  calc_operand_fsm #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural adder_8bit sitting downstream of the DUT.
  assign bus.add_sum = 9'({1'b0, bus.add_a} + {1'b0, bus.add_b} + 9'(bus.add_cin));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {negative, carry_out, result} from plain integer arithmetic.
  function automatic logic [9:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic op);
    int s;
    logic [9:0] r;
    s = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    r[7:0] = 8'(s);
    r[8]   = !op && (s > 255);
    r[9]   = op && (s < 0);
    return r;
  endfunction

  task automatic press(input logic [7:0] d, input logic op);
    @(negedge clk);
    bus.data_in = d;
    bus.op_in   = op;
    bus.enter   = 1'b1;
    @(negedge clk);
    bus.enter   = 1'b0;
  endtask

  // Full calculation from IDLE or DONE, checking each stage.
  task automatic calc(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op);
    logic [9:0] e;
    e = ref_calc(a, b, op);
    press(a, 1'b0);
    chk({tag, ".state_a"}, 32'(bus.state_out), 32'd1);
    chk({tag, ".valid_a"}, 32'(bus.result_valid), 32'd0);
    press(b, op);
    chk({tag, ".state_x"}, 32'(bus.state_out), 32'd2);
    chk({tag, ".add_a"},   32'(bus.add_a), 32'(a));
    chk({tag, ".add_b"},   32'(bus.add_b), op ? 32'(8'(~b)) : 32'(b));
    chk({tag, ".add_cin"}, 32'(bus.add_cin), 32'(op));
    @(negedge clk);
    chk({tag, ".state_d"}, 32'(bus.state_out), 32'd3);
    chk({tag, ".valid"},   32'(bus.result_valid), 32'd1);
    chk({tag, ".result"},  32'(bus.result), 32'(e[7:0]));
    chk({tag, ".carry"},   32'(bus.carry_out), 32'(e[8]));
    chk({tag, ".neg"},     32'(bus.negative), 32'(e[9]));
  endtask

  initial begin
    logic [7:0] held;
    logic [9:0] e;
    rst         = 1'b1;
    bus.data_in = '0;
    bus.op_in   = 1'b0;
    bus.enter   = 1'b0;
    bus.clear   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.state",  32'(bus.state_out), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.valid",  32'(bus.result_valid), 32'd0);
    chk("rst.carry",  32'(bus.carry_out), 32'd0);
    chk("rst.neg",    32'(bus.negative), 32'd0);
    chk("rst.add_a",  32'(bus.add_a), 32'd0);
    rst = 1'b0;

    calc("add1",   8'h01, 8'h01, 1'b0);
    calc("addff",  8'hFF, 8'h01, 1'b0);
    calc("add80",  8'h80, 8'h80, 1'b0);
    calc("sub0f",  8'h0F, 8'h05, 1'b1);
    calc("sub05",  8'h05, 8'h0F, 1'b1);
    calc("subeq",  8'h5A, 8'h5A, 1'b1);

    // Holding enter yields a single edge: stays in GOT_A.
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clr.state", 32'(bus.state_out), 32'd0);
    bus.data_in = 8'h33;
    bus.enter   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.state", 32'(bus.state_out), 32'd1);
    end
    bus.enter = 1'b0;
    @(negedge clk);
    chk("hold.rel", 32'(bus.state_out), 32'd1);
    chk("hold.a",   32'(bus.add_a), 32'h33);

    // Clear together with the B enter edge: aborted, back to IDLE with A cleared.
    bus.enter = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    chk("clrb.state", 32'(bus.state_out), 32'd0);
    chk("clrb.a",     32'(bus.add_a), 32'd0);
    @(negedge clk);
    chk("clrb.noexec", 32'(bus.state_out), 32'd0);

    // Clear in DONE drops valid but keeps the result.
    calc("pre", 8'h21, 8'h42, 1'b0);
    held = bus.result;
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clrd.valid",  32'(bus.result_valid), 32'd0);
    chk("clrd.state",  32'(bus.state_out), 32'd0);
    chk("clrd.result", 32'(bus.result), 32'(held));
    chk("clrd.carry",  32'(bus.carry_out), 32'd0);

    // Reset during EXEC: everything zero, result not taken from the adder.
    press(8'hF0, 1'b0);
    press(8'h20, 1'b0);
    chk("rx.state", 32'(bus.state_out), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rx.state2", 32'(bus.state_out), 32'd0);
    chk("rx.result", 32'(bus.result), 32'd0);
    chk("rx.carry",  32'(bus.carry_out), 32'd0);
    chk("rx.valid",  32'(bus.result_valid), 32'd0);
    chk("rx.add_b",  32'(bus.add_b), 32'd0);

    // Clear during EXEC: aborted, result keeps its previous value.
    calc("pre2", 8'h10, 8'h03, 1'b1);
    e = ref_calc(8'h10, 8'h03, 1'b1);
    press(8'h99, 1'b0);
    press(8'h11, 1'b0);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("cx.state",  32'(bus.state_out), 32'd0);
    chk("cx.result", 32'(bus.result), 32'(e[7:0]));
    chk("cx.neg",    32'(bus.negative), 32'(e[9]));

    // Randomized operands and operators, chained back to back from DONE.
    for (int i = 0; i < 24; i++) begin
      calc("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
